// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for a single-slope ramp ADC: shares one counter and ramp
// switch across NUM_SENSORS comparators, converting a latched channel mask in order.
module adc_conv_ctrl #(
  parameter int WIDTH         = 8,
  parameter int NUM_SENSORS   = 4,
  parameter int SETTLE_CYCLES = 4,
  localparam int CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [NUM_SENSORS-1:0] i_scan_mask,
  input  logic [NUM_SENSORS-1:0] i_comp_in,
  input  logic [WIDTH-1:0]       i_count_val,
  output logic                   o_count_en,
  output logic                   o_count_clr,
  output logic                   o_ramp_rst,
  output logic [CH_W-1:0]        o_ch_sel,
  output logic                   o_busy,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [WIDTH-1:0]       o_res_data,
  output logic [CH_W-1:0]        o_res_ch,
  output logic                   o_res_ovf,
  output logic [1:0]             o_state
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RAMP   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [NUM_SENSORS-1:0] r_pending;
  logic [SC_W-1:0]        r_settle_cnt;
  logic [CH_W-1:0]        r_ch_sel;
  logic                   r_count_en;
  logic                   r_count_clr;
  logic                   r_ramp_rst;
  logic                   r_busy;
  logic                   r_res_valid;
  logic [WIDTH-1:0]       r_res_data;
  logic [CH_W-1:0]        r_res_ch;
  logic                   r_res_ovf;

  logic                   w_comp;
  logic                   w_cnt_max;
  logic [NUM_SENSORS-1:0] w_pending_next;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_SENSORS-1:0] m);
    lowest_set = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  assign w_comp         = i_comp_in[r_ch_sel];
  assign w_cnt_max      = &i_count_val;
  assign w_pending_next = r_pending & ~(NUM_SENSORS'(1) << r_ch_sel);

  // Result handshake: o_res_valid rises on entry to HOLD and keeps res_data/ch/ovf
  // stable until a cycle with o_res_valid & i_res_ready; that edge is the transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_settle_cnt <= '0;
      r_ch_sel     <= '0;
      r_count_en   <= 1'b0;
      r_count_clr  <= 1'b0;
      r_ramp_rst   <= 1'b1;
      r_busy       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_ch     <= '0;
      r_res_ovf    <= 1'b0;
    end else begin
      r_count_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && (|i_scan_mask)) begin
            r_pending    <= i_scan_mask;
            r_ch_sel     <= lowest_set(i_scan_mask);
            r_count_clr  <= 1'b1;
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SC_W'(SETTLE_CYCLES - 1)) begin
            r_ramp_rst <= 1'b0;
            r_count_en <= 1'b1;
            r_state    <= S_RAMP;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_RAMP: begin
          // At full scale count_val is all-ones, so capturing it covers both exits;
          // a comparator hit on that same cycle is a real conversion, not overflow.
          if (w_comp || w_cnt_max) begin
            r_res_data  <= i_count_val;
            r_res_ovf   <= ~w_comp;
            r_res_ch    <= r_ch_sel;
            r_res_valid <= 1'b1;
            r_ramp_rst  <= 1'b1;
            r_count_en  <= 1'b0;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_pending   <= w_pending_next;
            if (|w_pending_next) begin
              r_ch_sel     <= lowest_set(w_pending_next);
              r_count_clr  <= 1'b1;
              r_settle_cnt <= '0;
              r_state      <= S_SETTLE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_count_en  = r_count_en;
  assign o_count_clr = r_count_clr;
  assign o_ramp_rst  = r_ramp_rst;
  assign o_ch_sel    = r_ch_sel;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_ch    = r_res_ch;
  assign o_res_ovf   = r_res_ovf;
  assign o_state     = r_state;

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Bench for adc_conv_ctrl: models the external counter and ramp comparators
// (comparator trips once the ramp count reaches a per-channel threshold).
module tb_adc_conv_ctrl;
  localparam int WIDTH = 8;
  localparam int NS    = 4;
  localparam int CH_W  = 2;
  localparam int SETTLE = 4;
  localparam int RW    = CH_W + WIDTH + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NS-1:0]     scan_mask;
  logic [NS-1:0]     comp_in = '0;
  logic [WIDTH-1:0]  count_val = '0;
  logic              count_en, count_clr, ramp_rst, busy, res_valid, res_ready, res_ovf;
  logic [CH_W-1:0]   ch_sel, res_ch;
  logic [WIDTH-1:0]  res_data;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int thr[NS];

  logic [RW-1:0]   exp_q[$];
  logic [RW-1:0]   got_q[$];
  int              ramp_q[$];
  int              settle_q[$];
  logic [CH_W-1:0] chsel_q[$];
  int              ramp_run = 0;
  int              settle_run = 0;
  int              clr_cnt = 0;

  adc_conv_ctrl #(.WIDTH(WIDTH), .NUM_SENSORS(NS), .SETTLE_CYCLES(SETTLE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_scan_mask(scan_mask),
    .i_comp_in(comp_in), .i_count_val(count_val), .o_count_en(count_en),
    .o_count_clr(count_clr), .o_ramp_rst(ramp_rst), .o_ch_sel(ch_sel),
    .o_busy(busy), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_ch(res_ch), .o_res_ovf(res_ovf),
    .o_state(dbg_state)
  );

  // clock / environment
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (count_clr)     count_val <= '0;
    else if (count_en) count_val <= count_val + 1'b1;
  end

  // Comparators are noisy while the ramp is discharged; otherwise they trip at threshold.
  always @(negedge clk) begin
    for (int c = 0; c < NS; c++)
      comp_in[c] = ramp_rst ? 1'($urandom_range(0, 1)) : (int'(count_val) >= thr[c]);
  end

  always @(negedge clk) begin
    if (rst) begin
      ramp_run   = 0;
      settle_run = 0;
    end else begin
      if (!ramp_rst) begin
        if (ramp_run == 0) chsel_q.push_back(ch_sel);
        ramp_run++;
      end else if (ramp_run > 0) begin
        ramp_q.push_back(ramp_run);
        ramp_run = 0;
      end
      if (busy && ramp_rst && !res_valid) settle_run++;
      else if (!ramp_rst && settle_run > 0) begin
        settle_q.push_back(settle_run);
        settle_run = 0;
      end
      if (count_clr) clr_cnt++;
      if (res_valid && res_ready) got_q.push_back({res_ch, res_data, res_ovf});
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  // driver / scoreboard tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {ramp_rst, count_en, count_clr, ch_sel, busy, res_valid, res_data, res_ch, res_ovf},
          {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0});
  endtask

  task automatic clear_monitors();
    got_q.delete(); ramp_q.delete(); settle_q.delete(); chsel_q.delete(); exp_q.delete();
    clr_cnt = 0;
  endtask

  task automatic run_scan(input string tag, input logic [NS-1:0] m, input int stall, input bit rnd_ready);
    int n = 0;
    bit done = 0;
    bit hold_seen = 0;
    logic [RW-1:0] hold_val = '0;
    int exp_len[$];
    logic [CH_W-1:0] exp_ch[$];
    clear_monitors();
    for (int c = 0; c < NS; c++) begin
      if (m[c]) begin
        exp_q.push_back({CH_W'(c), WIDTH'((thr[c] >= 255) ? 255 : thr[c]), (thr[c] > 255)});
        exp_len.push_back(((thr[c] >= 255) ? 255 : thr[c]) + 1);
        exp_ch.push_back(CH_W'(c));
        n++;
      end
    end
    res_ready = 1'b1;
    start = 1'b1;
    scan_mask = m;
    @(posedge clk); #1;
    check({tag, "_start"}, {busy, count_clr, ramp_rst}, 3'b111);
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      start = (busy && !res_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      scan_mask = NS'($urandom);
      if (res_valid && stall > 0) begin
        if (!hold_seen) begin
          hold_val = {res_ch, res_data, res_ovf};
          hold_seen = 1;
        end
        check({tag, "_hold"}, {res_valid, res_ch, res_data, res_ovf, ramp_rst, count_en, count_clr},
              {1'b1, hold_val, 1'b1, 1'b0, 1'b0});
        res_ready = 1'b0;
        stall--;
      end else begin
        res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    start = 1'b0;
    res_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_nres"}, got_q.size(), n);
    check({tag, "_nclr"}, clr_cnt, n);
    while (exp_q.size() > 0) begin
      logic [RW-1:0] e = exp_q.pop_front();
      int el = exp_len.pop_front();
      logic [CH_W-1:0] ec = exp_ch.pop_front();
      if (got_q.size() > 0) check({tag, "_res"}, got_q.pop_front(), e);
      if (ramp_q.size() > 0) check({tag, "_ramplen"}, ramp_q.pop_front(), el);
      else check({tag, "_ramplen_missing"}, 0, el);
      if (settle_q.size() > 0) check({tag, "_settle"}, settle_q.pop_front(), SETTLE);
      else check({tag, "_settle_missing"}, 0, SETTLE);
      if (chsel_q.size() > 0) check({tag, "_chsel"}, chsel_q.pop_front(), ec);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; scan_mask = '0; res_ready = 1'b0;
    for (int c = 0; c < NS; c++) thr[c] = 300;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // single channel, k=10
    thr[0] = 10;
    run_scan("single", 4'b0001, 0, 0);

    // ascending scan order
    thr[1] = 5; thr[3] = 200;
    run_scan("order", 4'b1010, 0, 0);

    // timeout, then comparator hit on the all-ones cycle
    thr[0] = 300;
    run_scan("timeout", 4'b0001, 0, 0);
    thr[0] = 255;
    run_scan("cmp_at_max", 4'b0001, 0, 0);

    // backpressure with two channels pending
    thr[0] = 30; thr[1] = 77;
    run_scan("backpr", 4'b0011, 20, 0);

    // comparator already high at ramp entry
    thr[0] = 0;
    run_scan("zero", 4'b0001, 0, 0);

    // empty mask is ignored
    start = 1'b1; scan_mask = 4'b0000;
    @(posedge clk); #1;
    start = 1'b0;
    check("mask0", {busy, count_clr, ramp_rst}, 3'b001);
    repeat (3) @(posedge clk);
    #1;
    check("mask0_idle", {busy, res_valid}, 2'b00);

    // reset mid-ramp at k=50
    thr[0] = 300;
    start = 1'b1; scan_mask = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && ramp_rst; i++) begin
      @(posedge clk); #1;
    end
    check("rampstart", ramp_rst, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    check("midramp_novalid", {res_valid, count_en}, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("midramp_rst");
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", {busy, res_valid, count_clr}, 3'b000);
    clear_monitors();
    thr[2] = 42;
    run_scan("after_rst", 4'b0100, 0, 0);

    // randomized scans
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NS; c++) thr[c] = $urandom_range(0, 300);
      run_scan("rand", NS'($urandom_range(1, 15)), $urandom_range(0, 5), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_conv_ctrl.md
Name: adc_conv_ctrl

Overview:
Conversion sequencer for the single-slope ramp ADC. It owns the shared free-running counter and ramp-reset switch and time-multiplexes them across NUM_SENSORS comparators. One start request converts every channel in a latched scan mask in ascending channel order. Each result is delivered through a valid/ready handshake tagged with channel and overflow flag.

Parameters:
WIDTH, 8, counter and result width
NUM_SENSORS, 4, number of comparator inputs / channels
SETTLE_CYCLES, 4, cycles ramp is held in reset before counting (>=1)
CH_W (localparam), max(1, clog2(NUM_SENSORS)), channel index width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request scan; sampled only in IDLE
scan_mask  in  NUM_SENSORS  channels to convert; latched with start
comp_in  in  NUM_SENSORS  comparator outputs, already synchronised to clk
count_val  in  WIDTH  external counter value
count_en  out  1  external counter enable
count_clr  out  1  external counter synchronous clear; count_val=0 next cycle
ramp_rst  out  1  holds ramp capacitor discharged when high
ch_sel  out  CH_W  active channel (analog mux select)
busy  out  1  high in every state except IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  converted value
res_ch  out  CH_W  channel of res_data
res_ovf  out  1  conversion timed out (counter reached all-ones)

Behaviour:
- Reset values: ramp_rst=1, count_en=0, count_clr=0, ch_sel=0, busy=0, res_valid=0, res_data=0, res_ch=0, res_ovf=0, pending mask=0, state=IDLE. rst at any time, including mid-RAMP or during HOLD, forces these on the next edge; partial results discarded.
- States: IDLE, SETTLE, RAMP, HOLD.
- IDLE: ramp_rst=1, count_en=0. start=1 with scan_mask!=0: latch mask as pending, ch_sel <= lowest set bit, pulse count_clr for one cycle, -> SETTLE. start with scan_mask==0 ignored (stay IDLE, busy stays 0).
- SETTLE: ramp_rst=1, count_en=0, exactly SETTLE_CYCLES cycles (internal counter), then -> RAMP. count_val is 0 throughout.
- RAMP: ramp_rst=0, count_en=1. Each cycle sample comp_in[ch_sel]: if 1, capture res_data=count_val, res_ovf=0, -> HOLD. Comp high on the first RAMP cycle yields 0; comp high in the k-th RAMP cycle (k from 0) yields k. If comp_in[ch_sel]=0 and count_val==all-ones: capture all-ones, res_ovf=1, -> HOLD (no wrap). Comparator wins when both occur: res_data all-ones, res_ovf=0.
- Capture cycle: count_en and ramp_rst take HOLD values on the same edge that enters HOLD; res_valid=1 from the first HOLD cycle (1-cycle latency after comparator sample). res_ch=ch_sel.
- HOLD: ramp_rst=1, count_en=0, res_valid=1; res_data/res_ch/res_ovf stable until accepted. On res_valid&res_ready: clear current bit in pending, res_valid=0 next cycle. If remaining pending!=0: ch_sel <= next lowest set bit, pulse count_clr, -> SETTLE. Else -> IDLE. res_data etc. hold their last values after acceptance.
- start and scan_mask changes while busy are ignored; no queuing.
- Non-existent channels: bits of scan_mask at or above NUM_SENSORS do not exist; no other masking.
- Only one output of count_clr per channel; count_clr is never high outside the IDLE->SETTLE or HOLD->SETTLE transition cycle.

Test Plan:
- Single channel: scan_mask=0001, start, comp_in[0] rises on 10th RAMP cycle (k=10), res_ready=1 -> ramp_rst low exactly 11 cycles after SETTLE_CYCLES=4 settle, res_valid one cycle, res_data=10, res_ch=0, res_ovf=0, back to IDLE, busy=0.
- Scan order: scan_mask=1010, comp rises at k=5 on ch1, k=200 on ch3 -> two results in order (ch1,5),(ch3,200); count_clr pulsed exactly twice; ch_sel=1 then 3.
- Timeout: WIDTH=8, comp_in held 0 -> after 256 RAMP cycles res_data=255, res_ovf=1; comp rising on that same cycle -> res_data=255, res_ovf=0.
- Backpressure: res_ready=0 for 20 HOLD cycles with comp toggling -> res_valid and res_data stable, ramp_rst=1, count_en=0, no next SETTLE until ready rises.
- Edge cases: start with scan_mask=0 -> busy stays 0; comp_in[0]=1 at RAMP entry -> res_data=0; start pulsed while busy -> ignored, no extra result.
- Reset mid-RAMP (k=50): rst one cycle -> next edge all outputs at reset values, no res_valid; subsequent start converts normally.
